power_sequencer: RTL and testbench



---
 rtl/power_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_power_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_sequencer.sv
// Rail power sequencer: ordered power-up with a per-step good timeout, timed reverse power-down,
// and latched all-rails-off fault shutdown. Define SEQ_FAULT_CLEAR_EN to add i_faultClear.
module power_sequencer #(
    parameter int unsigned NUM_RAILS       = 4,
    parameter int unsigned STEP_TIMEOUT    = 4000,
    parameter int unsigned POWERDOWN_DELAY = 100
) (
    input  logic                 i_clk,
    input  logic                 i_resetN,
    input  logic                 i_start,
    input  logic [NUM_RAILS-1:0] i_railGood,
    input  logic [NUM_RAILS-1:0] i_railFault,
`ifdef SEQ_FAULT_CLEAR_EN
    input  logic                 i_faultClear,
`endif
    output logic [NUM_RAILS-1:0] o_railEnable,
    output logic                 o_allGood,
    output logic                 o_busy,
    output logic                 o_fault,
    output logic [2:0]           o_faultRail,
    output logic                 o_faultTimeout
);

    localparam int unsigned TIMER_W = 12;
    localparam int unsigned IDX_W   = 3;

    localparam logic [TIMER_W-1:0]   TIMER_MAX  = '1;
    localparam logic [TIMER_W-1:0]   STEP_LIMIT = TIMER_W'(STEP_TIMEOUT);
    localparam logic [TIMER_W-1:0]   DOWN_LIMIT = TIMER_W'(POWERDOWN_DELAY);
    localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_RAILS - 1);
    localparam logic [NUM_RAILS-1:0] RAIL0      = NUM_RAILS'(1);

    typedef enum logic [2:0] {
        IDLE,
        POWER_UP,
        RUNNING,
        POWER_DOWN,
        FAULT
    } seqState_e;

    seqState_e            state;
    logic [IDX_W-1:0]     stepIdx;
    logic [TIMER_W-1:0]   timer;

    logic [TIMER_W-1:0]   timerInc;
    logic [NUM_RAILS-1:0] stepMask;
    logic                 stepGood;
    logic [NUM_RAILS-1:0] faultMask;
    logic [NUM_RAILS-1:0] runMask;

    // Enables are always a contiguous run from rail 0, so dropping the top set bit sheds the last rail.
    function automatic logic [NUM_RAILS-1:0] clearHighest(input logic [NUM_RAILS-1:0] v);
        logic [NUM_RAILS-1:0] r;
        logic                 done;
        r    = v;
        done = 1'b0;
        for (int i = int'(NUM_RAILS) - 1; i >= 0; i--) begin
            if (!done && v[i]) begin
                r[i] = 1'b0;
                done = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] lowestIdx(input logic [NUM_RAILS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(NUM_RAILS) - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    assign timerInc  = (timer == TIMER_MAX) ? timer : timer + TIMER_W'(1);
    assign stepMask  = RAIL0 << stepIdx;
    assign stepGood  = |(i_railGood & stepMask);
    assign faultMask = i_railFault & o_railEnable;
    assign runMask   = faultMask | ~i_railGood;

    // Sequencer state and registered outputs; priority is fault > timeout > stop > advance.
    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            state          <= IDLE;
            stepIdx        <= '0;
            timer          <= '0;
            o_railEnable   <= '0;
            o_allGood      <= 1'b0;
            o_busy         <= 1'b0;
            o_fault        <= 1'b0;
            o_faultRail    <= '0;
            o_faultTimeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state        <= POWER_UP;
                        stepIdx      <= '0;
                        timer        <= '0;
                        o_railEnable <= RAIL0;
                        o_busy       <= 1'b1;
                    end
                end

                POWER_UP: begin
                    timer <= timerInc;
                    if (|faultMask) begin
                        state          <= FAULT;
                        o_railEnable   <= '0;
                        o_busy         <= 1'b0;
                        o_fault        <= 1'b1;
                        o_faultRail    <= lowestIdx(faultMask);
                        o_faultTimeout <= 1'b0;
                    end else if (!stepGood && (timerInc >= STEP_LIMIT)) begin
                        state          <= FAULT;
                        o_railEnable   <= '0;
                        o_busy         <= 1'b0;
                        o_fault        <= 1'b1;
                        o_faultRail    <= stepIdx;
                        o_faultTimeout <= 1'b1;
                    end else if (!i_start) begin
                        state        <= POWER_DOWN;
                        o_railEnable <= clearHighest(o_railEnable);
                        timer        <= '0;
                    end else if (stepGood) begin
                        if (stepIdx == LAST_IDX) begin
                            state     <= RUNNING;
                            o_busy    <= 1'b0;
                            o_allGood <= 1'b1;
                        end else begin
                            stepIdx      <= stepIdx + IDX_W'(1);
                            timer        <= '0;
                            o_railEnable <= o_railEnable | (stepMask << 1);
                        end
                    end
                end

                RUNNING: begin
                    if (|runMask) begin
                        state          <= FAULT;
                        o_railEnable   <= '0;
                        o_allGood      <= 1'b0;
                        o_fault        <= 1'b1;
                        o_faultRail    <= lowestIdx(runMask);
                        o_faultTimeout <= 1'b0;
                    end else if (!i_start) begin
                        state        <= POWER_DOWN;
                        o_railEnable <= clearHighest(o_railEnable);
                        o_allGood    <= 1'b0;
                        o_busy       <= 1'b1;
                        timer        <= '0;
                    end
                end

                POWER_DOWN: begin
                    if (|faultMask) begin
                        state          <= FAULT;
                        o_railEnable   <= '0;
                        o_busy         <= 1'b0;
                        o_fault        <= 1'b1;
                        o_faultRail    <= lowestIdx(faultMask);
                        o_faultTimeout <= 1'b0;
                    end else if (timerInc >= DOWN_LIMIT) begin
                        timer <= '0;
                        if (o_railEnable == '0) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            o_railEnable <= clearHighest(o_railEnable);
                        end
                    end else begin
                        timer <= timerInc;
                    end
                end

                FAULT: begin
`ifdef SEQ_FAULT_CLEAR_EN
                    if (i_faultClear && !i_start) begin
                        state          <= IDLE;
                        o_fault        <= 1'b0;
                        o_faultRail    <= '0;
                        o_faultTimeout <= 1'b0;
                    end
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_power_sequencer.sv
// Self-checking bench for power_sequencer: vector table, directed corner sequences and
// randomized episodes checked against a rail-count reference model.
module tb_power_sequencer;

    localparam int NR    = 3;
    localparam int TO    = 10;
    localparam int DELAY = 5;

    localparam int PH_IDLE = 0;
    localparam int PH_UP   = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_DOWN = 3;
    localparam int PH_FLT  = 4;

    logic          clk;
    logic          resetN;
    logic          start;
    logic [NR-1:0] good;
    logic [NR-1:0] fault;
    logic          faultClear;
    logic [NR-1:0] railEnable;
    logic          allGood;
    logic          busy;
    logic          faultO;
    logic [2:0]    faultRail;
    logic          faultTo;

    int compared;
    int mismatched;

    // Reference model: phase, count of rails on, cycles waited in the current step
    int mPhase, mOn, mWait, mRail, mTo;

    power_sequencer #(
        .NUM_RAILS(NR),
        .STEP_TIMEOUT(TO),
        .POWERDOWN_DELAY(DELAY)
    ) dut (
        .i_clk(clk),
        .i_resetN(resetN),
        .i_start(start),
        .i_railGood(good),
        .i_railFault(fault),
`ifdef SEQ_FAULT_CLEAR_EN
        .i_faultClear(faultClear),
`endif
        .o_railEnable(railEnable),
        .o_allGood(allGood),
        .o_busy(busy),
        .o_fault(faultO),
        .o_faultRail(faultRail),
        .o_faultTimeout(faultTo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] pk(input logic [2:0] en, input logic ag, input logic bz,
                                      input logic fl, input logic [2:0] rl, input logic tm);
        return {en, ag, bz, fl, rl, tm};
    endfunction

    function automatic logic [9:0] actVec();
        return {railEnable, allGood, busy, faultO, faultRail, faultTo};
    endfunction

    function automatic logic [2:0] modelEn();
        return 3'((1 << mOn) - 1);
    endfunction

    function automatic logic [9:0] modelVec();
        return pk(modelEn(), mPhase == PH_RUN, (mPhase == PH_UP) || (mPhase == PH_DOWN),
                  mPhase == PH_FLT, 3'(mRail), 1'(mTo));
    endfunction

    function automatic int lowestSet(input logic [2:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic modelReset();
        mPhase = PH_IDLE; mOn = 0; mWait = 0; mRail = 0; mTo = 0;
    endtask

    task automatic modelFault(input int rail, input int tmo);
        mPhase = PH_FLT; mOn = 0; mRail = rail; mTo = tmo;
    endtask

    task automatic modelStep(input logic st, input logic [2:0] g, input logic [2:0] f, input logic clr);
        logic [2:0] fm;
        logic [2:0] rm;
        int         k;
        fm = f & modelEn();
        rm = fm | ~g;
        k  = mOn - 1;
        case (mPhase)
            PH_IDLE: if (st) begin mPhase = PH_UP; mOn = 1; mWait = 0; end
            PH_UP: begin
                if (mWait < 4095) mWait++;
                if (fm != 0) modelFault(lowestSet(fm), 0);
                else if (!g[k] && mWait >= TO) modelFault(k, 1);
                else if (!st) begin mPhase = PH_DOWN; mOn--; mWait = 0; end
                else if (g[k]) begin
                    if (mOn == NR) mPhase = PH_RUN;
                    else begin mOn++; mWait = 0; end
                end
            end
            PH_RUN: begin
                if (rm != 0) modelFault(lowestSet(rm), 0);
                else if (!st) begin mPhase = PH_DOWN; mOn--; mWait = 0; end
            end
            PH_DOWN: begin
                if (fm != 0) modelFault(lowestSet(fm), 0);
                else begin
                    mWait++;
                    if (mWait >= DELAY) begin
                        if (mOn == 0) mPhase = PH_IDLE;
                        else mOn--;
                        mWait = 0;
                    end
                end
            end
            default: if (clr && !st) begin mPhase = PH_IDLE; mRail = 0; mTo = 0; end
        endcase
    endtask

    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] act;
        act = actVec();
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @%0t: got en=%b ag=%b busy=%b flt=%b rail=%0d to=%b, want en=%b ag=%b busy=%b flt=%b rail=%0d to=%b",
                     name, $time, act[9:7], act[6], act[5], act[4], act[3:1], act[0],
                     exp[9:7], exp[6], exp[5], exp[4], exp[3:1], exp[0]);
        end
    endtask

    task automatic applyReset();
        resetN = 1'b0; start = 1'b0; good = '0; fault = '0; faultClear = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        modelReset();
    endtask

    task automatic cyc(input logic s, input logic [2:0] g, input logic [2:0] f);
        start = s; good = g; fault = f;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       start;
        logic [2:0] good;
        logic [2:0] flt;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[14];
    int   lat[NR];
    int   age[NR];
    logic st;
    logic clr;
    logic [2:0] en;
    logic [2:0] g;
    logic [2:0] f;

    initial begin
        compared   = 0;
        mismatched = 0;
        resetN     = 1'b0;
        start      = 1'b0;
        good       = '0;
        fault      = '0;
        faultClear = 1'b0;
        modelReset();

        // Normal power-up (good 3 cycles after each enable), run, then a run fault
        vecs[0]  = '{1'b1, 3'b000, 3'b000, pk(3'b001, 0, 1, 0, 3'd0, 0)};
        vecs[1]  = '{1'b1, 3'b000, 3'b000, pk(3'b001, 0, 1, 0, 3'd0, 0)};
        vecs[2]  = '{1'b1, 3'b000, 3'b000, pk(3'b001, 0, 1, 0, 3'd0, 0)};
        vecs[3]  = '{1'b1, 3'b001, 3'b000, pk(3'b011, 0, 1, 0, 3'd0, 0)};
        vecs[4]  = '{1'b1, 3'b001, 3'b000, pk(3'b011, 0, 1, 0, 3'd0, 0)};
        vecs[5]  = '{1'b1, 3'b001, 3'b000, pk(3'b011, 0, 1, 0, 3'd0, 0)};
        vecs[6]  = '{1'b1, 3'b011, 3'b000, pk(3'b111, 0, 1, 0, 3'd0, 0)};
        vecs[7]  = '{1'b1, 3'b011, 3'b000, pk(3'b111, 0, 1, 0, 3'd0, 0)};
        vecs[8]  = '{1'b1, 3'b011, 3'b000, pk(3'b111, 0, 1, 0, 3'd0, 0)};
        vecs[9]  = '{1'b1, 3'b111, 3'b000, pk(3'b111, 1, 0, 0, 3'd0, 0)};
        vecs[10] = '{1'b1, 3'b111, 3'b000, pk(3'b111, 1, 0, 0, 3'd0, 0)};
        vecs[11] = '{1'b1, 3'b111, 3'b110, pk(3'b000, 0, 0, 1, 3'd1, 0)};
        vecs[12] = '{1'b1, 3'b000, 3'b000, pk(3'b000, 0, 0, 1, 3'd1, 0)};
        vecs[13] = '{1'b0, 3'b000, 3'b000, pk(3'b000, 0, 0, 1, 3'd1, 0)};

        applyReset();
        check("reset", pk(3'b000, 0, 0, 0, 3'd0, 0));
        for (int i = 0; i < 14; i++) begin
            cyc(vecs[i].start, vecs[i].good, vecs[i].flt);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Fault is sticky regardless of start activity
        for (int i = 0; i < 50; i++) begin
            cyc(1'(i % 2), 3'b000, 3'b000);
            check("fault_hold", pk(3'b000, 0, 0, 1, 3'd1, 0));
        end

`ifdef SEQ_FAULT_CLEAR_EN
        faultClear = 1'b1;
        cyc(1'b1, 3'b000, 3'b000);
        check("clear_ignored_start_hi", pk(3'b000, 0, 0, 1, 3'd1, 0));
        cyc(1'b0, 3'b000, 3'b000);
        check("clear_to_idle", pk(3'b000, 0, 0, 0, 3'd0, 0));
        faultClear = 1'b0;
        cyc(1'b1, 3'b000, 3'b000);
        check("clear_restart", pk(3'b001, 0, 1, 0, 3'd0, 0));
`endif

        // Step timeout on rail 1: fault exactly TO cycles after its enable
        applyReset();
        cyc(1'b1, 3'b000, 3'b000);
        check("to_en0", pk(3'b001, 0, 1, 0, 3'd0, 0));
        cyc(1'b1, 3'b001, 3'b000);
        check("to_en1", pk(3'b011, 0, 1, 0, 3'd0, 0));
        for (int n = 1; n < TO; n++) begin
            cyc(1'b1, 3'b001, 3'b000);
            check("to_wait", pk(3'b011, 0, 1, 0, 3'd0, 0));
        end
        cyc(1'b1, 3'b001, 3'b000);
        check("to_fire", pk(3'b000, 0, 0, 1, 3'd1, 1));

        // Ordered power-down with ignored start pulses
        applyReset();
        cyc(1'b1, 3'b111, 3'b000);
        cyc(1'b1, 3'b111, 3'b000);
        cyc(1'b1, 3'b111, 3'b000);
        check("dn_up_last", pk(3'b111, 0, 1, 0, 3'd0, 0));
        cyc(1'b1, 3'b111, 3'b000);
        check("dn_running", pk(3'b111, 1, 0, 0, 3'd0, 0));
        for (int e = 1; e <= 17; e++) begin
            cyc((e == 3) || (e == 8) || (e == 13), 3'b111, 3'b000);
            check($sformatf("dn_e%0d", e),
                  pk((e < 6) ? 3'b011 : (e < 11) ? 3'b001 : 3'b000, 0, e < 16, 0, 3'd0, 0));
        end

        // Good on last rail and fault on rail 0 in the same cycle
        applyReset();
        cyc(1'b1, 3'b011, 3'b000);
        cyc(1'b1, 3'b011, 3'b000);
        cyc(1'b1, 3'b011, 3'b000);
        check("sim_en2", pk(3'b111, 0, 1, 0, 3'd0, 0));
        cyc(1'b1, 3'b111, 3'b001);
        check("sim_fault", pk(3'b000, 0, 0, 1, 3'd0, 0));
        cyc(1'b1, 3'b111, 3'b000);
        check("sim_hold", pk(3'b000, 0, 0, 1, 3'd0, 0));

        // Asynchronous reset mid power-up
        applyReset();
        cyc(1'b1, 3'b001, 3'b000);
        cyc(1'b1, 3'b001, 3'b000);
        check("ar_pre", pk(3'b011, 0, 1, 0, 3'd0, 0));
        #2;
        resetN = 1'b0;
        #1;
        check("ar_async", pk(3'b000, 0, 0, 0, 3'd0, 0));
        @(negedge clk);
        resetN = 1'b1;

        // Randomized episodes against the reference model
        for (int ep = 0; ep < 40; ep++) begin
            applyReset();
            check("rand_reset", modelVec());
            for (int k = 0; k < NR; k++) begin
                lat[k] = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(1, 6));
                age[k] = 0;
            end
            st = 1'b1;
            for (int c = 0; c < 80; c++) begin
                if ($urandom_range(0, 24) == 0) st = ~st;
                en = modelEn();
                for (int k = 0; k < NR; k++)
                    g[k] = en[k] && (age[k] >= lat[k]) && ($urandom_range(0, 199) != 0);
                f = ($urandom_range(0, 149) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
`ifdef SEQ_FAULT_CLEAR_EN
                clr = ($urandom_range(0, 9) == 0);
`else
                clr = 1'b0;
`endif
                faultClear = clr;
                cyc(st, g, f);
                modelStep(st, g, f, clr);
                check("rand", modelVec());
                en = modelEn();
                for (int k = 0; k < NR; k++) age[k] = en[k] ? age[k] + 1 : 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
